// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory arbiter.
//   - default IMEM window (byte base, depth in words)
//   - requester/owner encoding
//   - addr_err(): alignment and window check on a byte address
package imem_pkg;

  localparam logic [31:0] IMEM_BASE_DEF = 32'h0000_0000;
  localparam int          IMEM_SIZE_DEF = 32768;

  localparam logic OWN_FETCH  = 1'b0;
  localparam logic OWN_LOADER = 1'b1;

  // One in-flight response slot: who owns it and how it must be returned.
  typedef struct packed {
    logic vld;
    logic own;
    logic wr;
    logic err;
  } rsp_slot_t;

  // The compare is 33 bits wide so a window ending exactly at 2^32 does not
  // wrap to zero and reject every address.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] win_bytes);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] != 2'b00) || (addr < base) || (off >= win_bytes);
  endfunction

endpackage

// File: rtl/imem_rr_arb2.sv
// imem_rr_arb2: two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_f      : fetch request valid
//   req_l      : loader request valid
//   gnt_f      : fetch granted (combinational)
//   gnt_l      : loader granted (combinational)
// A grant is always an acceptance (grant implies valid), so last_grant
// moves on every grant. Reset leaves last_grant = loader, giving fetch the
// first conflict.
module imem_rr_arb2
  import imem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_f,
  input  logic req_l,
  output logic gnt_f,
  output logic gnt_l
);

  logic last_grant;

  always_comb begin
    gnt_f = req_f && (!req_l || (last_grant == OWN_LOADER));
    gnt_l = req_l && !gnt_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= OWN_LOADER;
    else if (gnt_f) last_grant <= OWN_FETCH;
    else if (gnt_l) last_grant <= OWN_LOADER;
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port, synchronous-read IMEM between the
// fetch stage (read-only) and the program loader (read/write).
//   clk, rst_n              : clock, asynchronous active-low reset
//   f_req_* / f_rsp_*       : fetch request (valid/ready/addr) and response
//   l_req_* / l_rsp_*       : loader request (valid/ready/we/addr/wdata) and response
//   mem_en/we/addr/wdata    : IMEM strobe, write enable, word index, write data
//   mem_rdata               : IMEM read data, one cycle after a read strobe
//   wlock                   : sticky write-lock request
// Build option: define IMEM_ARB_WLOCK_EN to honour wlock; otherwise wlock is
// ignored and loader writes are always permitted.
// One access per cycle, response exactly one cycle after acceptance.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
  parameter int          IMEM_SIZE = IMEM_SIZE_DEF,
  parameter int          AW        = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req_valid,
  output logic          f_req_ready,
  input  logic [31:0]   f_req_addr,
  output logic          f_rsp_valid,
  output logic [31:0]   f_rsp_data,
  output logic          f_rsp_err,
  input  logic          l_req_valid,
  output logic          l_req_ready,
  input  logic          l_req_we,
  input  logic [31:0]   l_req_addr,
  input  logic [31:0]   l_req_wdata,
  output logic          l_rsp_valid,
  output logic [31:0]   l_rsp_data,
  output logic          l_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          wlock
);

  localparam logic [32:0] WIN_BYTES = 33'(IMEM_SIZE) << 2;

  logic        gnt_f, gnt_l, accept, err, wr_req, lock_err;
  logic [31:0] sel_addr, off;
  rsp_slot_t   rsp_q;

  imem_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_f (f_req_valid),
    .req_l (l_req_valid),
    .gnt_f (gnt_f),
    .gnt_l (gnt_l)
  );

`ifdef IMEM_ARB_WLOCK_EN
  // Sticky: once set only reset clears it. Registered, so it bites the
  // cycle after wlock rises.
  logic locked;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     locked <= 1'b0;
    else if (wlock) locked <= 1'b1;
  end
  assign lock_err = locked && wr_req;
`else
  logic unused_wlock;
  assign unused_wlock = wlock;
  assign lock_err     = 1'b0;
`endif

  assign f_req_ready = gnt_f;
  assign l_req_ready = gnt_l;
  assign accept      = gnt_f || gnt_l;
  assign wr_req      = gnt_l && l_req_we;
  assign sel_addr    = gnt_l ? l_req_addr : f_req_addr;
  assign off         = sel_addr - IMEM_BASE;
  assign err         = accept && (addr_err(sel_addr, IMEM_BASE, WIN_BYTES) || lock_err);

  // Address/data buses sit at zero whenever no access is strobed.
  assign mem_en    = accept && !err;
  assign mem_we    = wr_req && !err;
  assign mem_addr  = mem_en ? off[AW+1:2] : '0;
  assign mem_wdata = mem_we ? l_req_wdata : '0;

  logic unused_off;
  assign unused_off = ^{off[31:AW+2], off[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q.vld <= accept;
      rsp_q.own <= gnt_l ? OWN_LOADER : OWN_FETCH;
      rsp_q.wr  <= wr_req;
      rsp_q.err <= err;
    end
  end

  // Read data is steered straight from the memory: it only becomes valid
  // in the response cycle, so it cannot be captured in the slot.
  logic rd_ok;
  assign rd_ok = rsp_q.vld && !rsp_q.wr && !rsp_q.err;

  assign f_rsp_valid = rsp_q.vld && (rsp_q.own == OWN_FETCH);
  assign f_rsp_err   = f_rsp_valid && rsp_q.err;
  assign f_rsp_data  = (rd_ok && rsp_q.own == OWN_FETCH) ? mem_rdata : '0;

  assign l_rsp_valid = rsp_q.vld && (rsp_q.own == OWN_LOADER);
  assign l_rsp_err   = l_rsp_valid && rsp_q.err;
  assign l_rsp_data  = (rd_ok && rsp_q.own == OWN_LOADER) ? mem_rdata : '0;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters:
  - the pipeline fetch stage (read-only);
  - the program loader (read/write, used for boot-time program download and readback).
- Arbitration is round-robin, one access per cycle, with a fixed 1-cycle response latency.
- Performs word-address translation and range/alignment checking against the IMEM window.
- Sits between the fetch stage / loader and the IMEM array.

Parameters:
- IMEM_BASE, 32'h0000_0000, byte base address of the IMEM window.
- IMEM_SIZE, 32768, depth in 32-bit words; must be a power of two.
- AW, 15, word-address width; equals log2(IMEM_SIZE).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req_valid  in  1  fetch read request.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_req_addr  in  32  fetch byte address.
- f_rsp_valid  out  1  fetch response valid; single-cycle pulse, no backpressure.
- f_rsp_data  out  32  fetch read data.
- f_rsp_err  out  1  fetch access fault.
- l_req_valid  in  1  loader request.
- l_req_ready  out  1  loader request accepted this cycle.
- l_req_we  in  1  1 = write, 0 = read.
- l_req_addr  in  32  loader byte address.
- l_req_wdata  in  32  loader write data.
- l_rsp_valid  out  1  loader response valid; single-cycle pulse, no backpressure.
- l_rsp_data  out  32  loader read data; 0 for writes.
- l_rsp_err  out  1  loader access fault.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.
- wlock  in  1  write-lock request; used only when IMEM_ARB_WLOCK_EN is defined, ignored otherwise.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - all *_rsp_valid, *_rsp_err, mem_en and mem_we are 0;
  - all data outputs are 0;
  - last_grant = LOADER, so fetch has priority on the first conflict.
- Handshake:
  - A request is accepted on a cycle with valid && ready.
  - ready is combinational from the valids and last_grant.
  - At most one of f_req_ready / l_req_ready is high in any cycle.
  - A requester may drop valid without acceptance.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - last_grant updates only on an accepted request.
  - Two requesters held continuously valid are granted alternately: F, L, F, L...
- Address check (combinational, on the granted request):
  - off = addr - IMEM_BASE.
  - err = (addr[1:0] != 0) || (addr < IMEM_BASE) || (off >= IMEM_SIZE*4).
  - Use a 33-bit compare so the window end at 2^32 does not wrap.
  - Fetch never writes; no write request exists on the fetch port.
- Memory drive, same cycle as acceptance:
  - mem_en = accept && !err.
  - mem_we = loader granted && l_req_we && !err.
  - mem_addr = off[AW+1:2]; mem_wdata = l_req_wdata.
- Response pipeline (one register stage: owner, is_write, err, valid):
  - The response asserts exactly 1 cycle after acceptance.
  - rsp_data = mem_rdata for successful reads; 0 for writes and errors.
  - An errored access never asserts mem_en, yet still produces its response 1 cycle later.
- Throughput: one access per cycle, fully pipelined. Back-to-back accepts produce back-to-back responses, each routed to its owner.
- Reset mid-operation: any in-flight response is discarded (rsp_valid = 0); the arbiter returns to reset priority.

Optional Feature:
- Macro: IMEM_ARB_WLOCK_EN.
- Defined:
  - A sticky lock flop sets when wlock = 1 and clears only on rst_n.
  - While locked, accepted loader writes behave as errors: mem_en = 0, l_rsp_err = 1 next cycle.
  - Loader reads and fetch are unaffected.
  - The lock flop takes effect the cycle after wlock rises.
- Undefined:
  - The wlock port exists but is ignored.
  - Loader writes are always permitted.

Decomposition:
- Shared package imem_pkg:
  - IMEM_BASE and IMEM_SIZE defaults;
  - owner encoding (OWN_FETCH = 1'b0, OWN_LOADER = 1'b1);
  - a function for the address-range/alignment check.
- One natural sub-module: imem_rr_arb2, a two-input round-robin arbiter holding the last_grant flop.
- The response pipeline and address check stay in imem_arbiter.

Test Plan:
- Fetch alone, addr 0x0000_0010, mem word 4 = 0xDEADBEEF:
  - mem_en=1, mem_addr=4 in cycle 0;
  - f_rsp_valid=1 with f_rsp_data=0xDEADBEEF in cycle 1.
- Both valid continuously for 4 cycles, from reset:
  - grants F, L, F, L;
  - responses alternate f/l, each exactly 1 cycle after its grant.
- Loader write addr 0x100, data 0x12345678, then fetch 0x100:
  - mem_we=1, mem_addr=0x40;
  - l_rsp_valid=1 with data 0;
  - the fetch returns 0x12345678.
- Error accesses produce mem_en=0 and an *_rsp_err=1 response next cycle:
  - fetch 0x0000_0002 (misaligned);
  - fetch 0x0002_0000 (= IMEM_SIZE*4, out of range);
  - loader 0xFFFF_FFFC with IMEM_BASE=0.
- rst_n pulled low the cycle after an accepted fetch: no f_rsp_valid is emitted; the first post-reset conflict grants fetch.
- With IMEM_ARB_WLOCK_EN: pulse wlock, then a loader write to 0x0 gives mem_en=0, l_rsp_err=1; a loader read of 0x0 still succeeds.
